// File: rtl/thread_fetch_scheduler_if.sv
// Fetch-scheduler bus: hazard/enable/miss reports in, fetch grant and status out.
// THREAD_SCHED_PERF_EN adds the per-thread grant counters and idle-cycle counter.
interface thread_fetch_scheduler_if #(
  parameter int NUM_THREADS = 4,
  parameter int TID_WIDTH   = $clog2(NUM_THREADS)
);
  logic                   i_stall;
  logic [NUM_THREADS-1:0] i_thread_en;
  logic                   i_block_valid;
  logic [TID_WIDTH-1:0]   i_block_tid;
  logic                   i_unblock_valid;
  logic [TID_WIDTH-1:0]   i_unblock_tid;
  logic                   o_fetch_valid;
  logic [TID_WIDTH-1:0]   o_fetch_tid;
  logic [NUM_THREADS-1:0] o_blocked;
  logic                   o_idle;
`ifdef THREAD_SCHED_PERF_EN
  logic [NUM_THREADS*32-1:0] o_grant_count;
  logic [31:0]               o_idle_cycles;
`endif

  modport master (
    output i_stall, i_thread_en, i_block_valid, i_block_tid,
           i_unblock_valid, i_unblock_tid,
    input  o_fetch_valid, o_fetch_tid, o_blocked, o_idle
`ifdef THREAD_SCHED_PERF_EN
    , input o_grant_count, o_idle_cycles
`endif
  );

  modport slave (
    input  i_stall, i_thread_en, i_block_valid, i_block_tid,
           i_unblock_valid, i_unblock_tid,
    output o_fetch_valid, o_fetch_tid, o_blocked, o_idle
`ifdef THREAD_SCHED_PERF_EN
    , output o_grant_count, o_idle_cycles
`endif
  );
endinterface

// File: rtl/thread_fetch_scheduler.sv
// Round-robin fetch-slot scheduler for the multithreaded core.
// Grants one thread per cycle for up to QUANTUM unstalled cycles, skipping
// disabled threads and threads blocked on an outstanding d-cache miss.
// Optional THREAD_SCHED_PERF_EN: per-thread grant counters and idle-cycle counter.

// One thread's miss-blocked bit; a same-cycle block beats the unblock.
module thread_block_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q,
  output logic q_next
);
  assign q_next = (q & ~clr) | set;

  // blocked bit follows its next value every edge, stall or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= q_next;
  end
endmodule

module thread_fetch_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int TID_WIDTH   = $clog2(NUM_THREADS),
  parameter int QUANTUM     = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  thread_fetch_scheduler_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [TID_WIDTH-1:0]   fetch_tid_q, fetch_tid_d;
  logic [TID_WIDTH-1:0]   last_tid_q, last_tid_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_THREADS-1:0] blk_set, blk_clr, blocked_q, blocked_d;
  logic [NUM_THREADS-1:0] eligible;
  logic [TID_WIDTH-1:0]   scan_base, scan_idx, pick_tid;

  // per-thread block/unblock decode
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_dec
    assign blk_set[t] = bus.i_block_valid   && (bus.i_block_tid   == TID_WIDTH'(t));
    assign blk_clr[t] = bus.i_unblock_valid && (bus.i_unblock_tid == TID_WIDTH'(t));
  end

  thread_block_cell u_blk [NUM_THREADS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (blk_set),
    .clr    (blk_clr),
    .q      (blocked_q),
    .q_next (blocked_d)
  );

  // uses next-cycle blocked state so a thread missing now is not granted next
  assign eligible = bus.i_thread_en & ~blocked_d;

  // Round-robin pick: first eligible thread after the base, base itself last.
  // While running, the base is the current owner (it becomes last_tid on rotation).
  always_comb begin
    scan_base = (state_q == S_RUN) ? fetch_tid_q : last_tid_q;
    scan_idx  = '0;
    pick_tid  = scan_base;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      scan_idx = scan_base + TID_WIDTH'(k);
      if (eligible[scan_idx]) pick_tid = scan_idx;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state: idle only reacts to eligibility; run holds under stall
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|eligible) state_d = S_RUN;
      S_RUN:   if (!bus.i_stall && !(|eligible)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // grant datapath next values: keep, extend quantum, or rotate
  always_comb begin
    fetch_tid_d = fetch_tid_q;
    last_tid_d  = last_tid_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          fetch_tid_d = pick_tid;
          cnt_d       = 4'd1;
        end
      end
      S_RUN: begin
        if (!bus.i_stall && (|eligible)) begin
          if (eligible[fetch_tid_q] && (cnt_q < 4'(QUANTUM))) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            last_tid_d  = fetch_tid_q;
            fetch_tid_d = pick_tid;
            cnt_d       = 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // grant datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_tid_q <= '0;
      last_tid_q  <= TID_WIDTH'(NUM_THREADS - 1);
      cnt_q       <= '0;
    end else begin
      fetch_tid_q <= fetch_tid_d;
      last_tid_q  <= last_tid_d;
      cnt_q       <= cnt_d;
    end
  end

  // valid/idle come straight off the single-bit state flop
  assign bus.o_fetch_valid = (state_q == S_RUN);
  assign bus.o_idle        = (state_q == S_IDLE);
  assign bus.o_fetch_tid   = fetch_tid_q;
  assign bus.o_blocked     = blocked_q;

`ifdef THREAD_SCHED_PERF_EN
  logic [NUM_THREADS-1:0][31:0] grant_cnt;
  logic [31:0]                  idle_cnt;

  // count unstalled granted cycles per owner and cycles spent idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (!bus.i_stall && state_q == S_RUN)
        grant_cnt[fetch_tid_q] <= grant_cnt[fetch_tid_q] + 32'd1;
      if (state_q == S_IDLE)
        idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign bus.o_grant_count = grant_cnt;
  assign bus.o_idle_cycles = idle_cnt;
`endif
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Bench for thread_fetch_scheduler: two instances (QUANTUM=1 and QUANTUM=3)
// share stimulus; a directed vector table, hand sequences for multi-cycle
// corners, and random traffic checked against a round-robin reference model.
module tb_thread_fetch_scheduler;
  localparam int NT = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] en = '0;
  logic       bv = 1'b0, uv = 1'b0;
  logic [1:0] bt = '0, ut = '0;

  int n_tests = 0, n_fail = 0;

  thread_fetch_scheduler_if #(.NUM_THREADS(NT)) bus1 ();
  thread_fetch_scheduler_if #(.NUM_THREADS(NT)) bus3 ();

  assign bus1.i_stall = stall;         assign bus3.i_stall = stall;
  assign bus1.i_thread_en = en;        assign bus3.i_thread_en = en;
  assign bus1.i_block_valid = bv;      assign bus3.i_block_valid = bv;
  assign bus1.i_block_tid = bt;        assign bus3.i_block_tid = bt;
  assign bus1.i_unblock_valid = uv;    assign bus3.i_unblock_valid = uv;
  assign bus1.i_unblock_tid = ut;      assign bus3.i_unblock_tid = ut;

  thread_fetch_scheduler #(.NUM_THREADS(NT), .TID_WIDTH(2), .QUANTUM(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  thread_fetch_scheduler #(.NUM_THREADS(NT), .TID_WIDTH(2), .QUANTUM(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  // reference model: who owns the slot, how long it has had it, rotation base
  int          qv[2] = '{1, 3};
  bit          m_run[2];
  int          m_cur[2], m_streak[2], m_last[2];
  logic [3:0]  m_blk;
  int unsigned m_gc[2][NT];
  int unsigned m_ic[2];

  function automatic int pick(int base, logic [3:0] el);
    for (int k = 1; k <= NT; k++) begin
      int t = (base + k) % NT;
      if (el[t]) return t;
    end
    return base;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_cur[d] = 0; m_streak[d] = 0; m_last[d] = NT - 1; m_ic[d] = 0;
      for (int t = 0; t < NT; t++) m_gc[d][t] = 0;
    end
    m_blk = '0;
  endtask

  task automatic model_step();
    logic [3:0] nb, el;
    nb = m_blk;
    if (uv) nb[ut] = 1'b0;
    if (bv) nb[bt] = 1'b1;
    el = en & ~nb;
    for (int d = 0; d < 2; d++) begin
      if (!stall && m_run[d]) m_gc[d][m_cur[d]]++;
      if (!m_run[d]) m_ic[d]++;
      if (!m_run[d]) begin
        if (el != 0) begin m_run[d] = 1; m_cur[d] = pick(m_last[d], el); m_streak[d] = 1; end
      end else if (!stall) begin
        if (el == 0) m_run[d] = 0;
        else if (el[m_cur[d]] && m_streak[d] < qv[d]) m_streak[d]++;
        else begin m_last[d] = m_cur[d]; m_cur[d] = pick(m_cur[d], el); m_streak[d] = 1; end
      end
    end
    m_blk = nb;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic v, i; logic [1:0] tid; logic [3:0] b;
      v   = (d == 0) ? bus1.o_fetch_valid : bus3.o_fetch_valid;
      i   = (d == 0) ? bus1.o_idle        : bus3.o_idle;
      tid = (d == 0) ? bus1.o_fetch_tid   : bus3.o_fetch_tid;
      b   = (d == 0) ? bus1.o_blocked     : bus3.o_blocked;
      chk($sformatf("%s q%0d valid", tag, qv[d]), 32'(v), 32'(m_run[d]));
      chk($sformatf("%s q%0d idle", tag, qv[d]), 32'(i), 32'(!m_run[d]));
      chk($sformatf("%s q%0d tid", tag, qv[d]), 32'(tid), 32'(m_cur[d]));
      chk($sformatf("%s q%0d blocked", tag, qv[d]), 32'(b), 32'(m_blk));
`ifdef THREAD_SCHED_PERF_EN
      for (int t = 0; t < NT; t++)
        chk($sformatf("%s q%0d grant%0d", tag, qv[d], t),
            (d == 0) ? bus1.o_grant_count[t*32 +: 32] : bus3.o_grant_count[t*32 +: 32], m_gc[d][t]);
      chk($sformatf("%s q%0d idlecyc", tag, qv[d]),
          (d == 0) ? bus1.o_idle_cycles : bus3.o_idle_cycles, m_ic[d]);
`endif
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 0; en = '0; bv = 0; uv = 0; bt = '0; ut = '0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic st; logic [3:0] en; logic bv; logic [1:0] bt; logic uv; logic [1:0] ut;
    logic v; logic [1:0] tid; logic [3:0] blk;
  } vec_t;

  function automatic vec_t mk(logic st, logic [3:0] e, logic b, logic [1:0] bti, logic u,
                              logic [1:0] uti, logic v, logic [1:0] tid, logic [3:0] blk);
    vec_t r;
    r.st = st; r.en = e; r.bv = b; r.bt = bti; r.uv = u; r.ut = uti;
    r.v = v; r.tid = tid; r.blk = blk;
    return r;
  endfunction

  initial begin
    vec_t tbl[24];
    int   seq_a[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int   seq_b[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 2};

    // QUANTUM=1 directed vectors, expectations for dut1
    tbl[0]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 0, 4'h0);
    tbl[1]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 1, 4'h0);
    tbl[2]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 2, 4'h0);
    tbl[3]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 3, 4'h0);
    tbl[4]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 0, 4'h0);
    tbl[5]  = mk(0, 4'hF, 1, 1, 0, 0, 1, 2, 4'h2);
    tbl[6]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 3, 4'h2);
    tbl[7]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 0, 4'h2);
    tbl[8]  = mk(0, 4'hF, 0, 0, 0, 0, 1, 2, 4'h2);
    tbl[9]  = mk(0, 4'hF, 0, 0, 1, 1, 1, 3, 4'h0);
    tbl[10] = mk(0, 4'hF, 0, 0, 0, 0, 1, 0, 4'h0);
    tbl[11] = mk(0, 4'hF, 0, 0, 0, 0, 1, 1, 4'h0);
    tbl[12] = mk(0, 4'h4, 0, 0, 0, 0, 1, 2, 4'h0);
    tbl[13] = mk(0, 4'h4, 0, 0, 0, 0, 1, 2, 4'h0);
    tbl[14] = mk(0, 4'h4, 1, 2, 0, 0, 0, 2, 4'h4);
    tbl[15] = mk(0, 4'hF, 0, 0, 0, 0, 1, 3, 4'h4);
    tbl[16] = mk(0, 4'hF, 1, 2, 1, 2, 1, 0, 4'h4);
    tbl[17] = mk(0, 4'hF, 0, 0, 1, 2, 1, 1, 4'h0);
    tbl[18] = mk(1, 4'hF, 0, 0, 0, 0, 1, 1, 4'h0);
    tbl[19] = mk(1, 4'hF, 0, 0, 1, 0, 1, 1, 4'h0);
    tbl[20] = mk(0, 4'hF, 0, 0, 0, 0, 1, 2, 4'h0);
    tbl[21] = mk(0, 4'hF, 1, 3, 0, 0, 1, 0, 4'h8);
    tbl[22] = mk(0, 4'hF, 1, 3, 0, 0, 1, 1, 4'h8);
    tbl[23] = mk(0, 4'hF, 0, 0, 1, 3, 1, 2, 4'h0);

    #2;
    do_reset();
    chk("rst valid", 32'(bus1.o_fetch_valid), 0);
    chk("rst idle", 32'(bus1.o_idle), 1);
    chk("rst tid", 32'(bus1.o_fetch_tid), 0);
    chk("rst blocked", 32'(bus1.o_blocked), 0);

    for (int r = 0; r < 24; r++) begin
      stall = tbl[r].st; en = tbl[r].en; bv = tbl[r].bv; bt = tbl[r].bt;
      uv = tbl[r].uv; ut = tbl[r].ut;
      step($sformatf("vec%0d", r));
      chk($sformatf("tbl%0d valid", r), 32'(bus1.o_fetch_valid), 32'(tbl[r].v));
      chk($sformatf("tbl%0d idle", r), 32'(bus1.o_idle), 32'(!tbl[r].v));
      chk($sformatf("tbl%0d tid", r), 32'(bus1.o_fetch_tid), 32'(tbl[r].tid));
      chk($sformatf("tbl%0d blocked", r), 32'(bus1.o_blocked), 32'(tbl[r].blk));
    end
    stall = 0; bv = 0; uv = 0;

    // QUANTUM=3 plain rotation
    do_reset();
    en = 4'hF;
    for (int i = 0; i < 9; i++) begin
      step($sformatf("q3a%0d", i));
      chk($sformatf("q3 seq%0d tid", i), 32'(bus3.o_fetch_tid), 32'(seq_a[i]));
    end

    // QUANTUM=3 with a two-cycle stall during thread 1's second cycle
    do_reset();
    en = 4'hF;
    for (int i = 0; i < 9; i++) begin
      stall = (i == 5 || i == 6);
      step($sformatf("q3b%0d", i));
      chk($sformatf("q3 stall seq%0d tid", i), 32'(bus3.o_fetch_tid), 32'(seq_b[i]));
    end
    stall = 0;

    // block every thread -> idle, then a single unblock resumes on that thread
    do_reset();
    en = 4'hF;
    step("ball0");
    for (int t = 0; t < NT; t++) begin
      bv = 1; bt = 2'(t);
      step($sformatf("ball_blk%0d", t));
    end
    bv = 0;
    chk("allblk valid", 32'(bus1.o_fetch_valid), 0);
    chk("allblk idle", 32'(bus1.o_idle), 1);
    chk("allblk blocked", 32'(bus1.o_blocked), 32'hF);
    uv = 1; ut = 2'd3;
    step("ball_unblk");
    uv = 0;
    chk("unblk3 valid", 32'(bus1.o_fetch_valid), 1);
    chk("unblk3 tid", 32'(bus1.o_fetch_tid), 3);

    // asynchronous reset mid-rotation with threads 0 and 2 blocked
    do_reset();
    en = 4'hF;
    bv = 1; bt = 2'd0; step("ar0");
    bt = 2'd2;         step("ar1");
    bv = 0;            step("ar2");
    step("ar3");
    chk("pre-areset blocked", 32'(bus1.o_blocked), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset q1 valid", 32'(bus1.o_fetch_valid), 0);
    chk("areset q1 idle", 32'(bus1.o_idle), 1);
    chk("areset q1 tid", 32'(bus1.o_fetch_tid), 0);
    chk("areset q1 blocked", 32'(bus1.o_blocked), 0);
    chk("areset q3 blocked", 32'(bus3.o_blocked), 0);
    chk("areset q3 valid", 32'(bus3.o_fetch_valid), 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      bv    = ($urandom_range(0, 3) == 0);
      bt    = 2'($urandom_range(0, 3));
      uv    = ($urandom_range(0, 2) == 0);
      ut    = 2'($urandom_range(0, 3));
      step($sformatf("rnd%0d", i));
    end
    stall = 0; bv = 0; uv = 0;

`ifdef THREAD_SCHED_PERF_EN
    // 100 unstalled granted cycles at QUANTUM=1 split evenly
    do_reset();
    en = 4'hF;
    for (int i = 0; i < 101; i++) step($sformatf("perf%0d", i));
    for (int t = 0; t < NT; t++)
      chk($sformatf("perf grant%0d", t), bus1.o_grant_count[t*32 +: 32], 32'd25);
    chk("perf idle cycles", bus1.o_idle_cycles, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
